// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and widths for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_GEMM = 2'd2
  } owner_e;

  localparam int LANE_W   = 2;
  localparam int MEM_DW   = 128;
  localparam int MASK_W   = 16;
  localparam int CPU_DW   = 32;
  localparam int CPU_MW   = 4;
  localparam int CTRL_W   = 5;
  localparam int STREAK_W = 4;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundles the CPU, GEMM and memory-side signals of the shared data-memory port.
interface dmem_port_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic                cpu_en;
  logic                cpu_rdwr;
  logic [CPU_MW-1:0]   cpu_mask;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [CPU_DW-1:0]   cpu_wr_data;
  logic [CPU_DW-1:0]   cpu_rd_data;
  logic                cpu_rd_valid;
  logic                cpu_stall;

  logic                gemm_en;
  logic                gemm_rdwr;
  logic [CTRL_W-1:0]   gemm_control;
  logic [ADDR_W-1:0]   gemm_addr;
  logic [MEM_DW-1:0]   gemm_wr_data;
  logic                gemm_grant;
  logic [MEM_DW-1:0]   gemm_rd_data;
  logic                gemm_rd_valid;

  logic                mem_en;
  logic                mem_rdwr;
  logic [CTRL_W-1:0]   mem_control;
  logic [MASK_W-1:0]   mem_mask;
  logic [ADDR_W-1:0]   mem_addr;
  logic [MEM_DW-1:0]   mem_wr_data;
  logic [MEM_DW-1:0]   mem_rd_data;

  // Arbiter side
  modport slave (
    input  cpu_en, cpu_rdwr, cpu_mask, cpu_addr, cpu_wr_data,
    output cpu_rd_data, cpu_rd_valid, cpu_stall,
    input  gemm_en, gemm_rdwr, gemm_control, gemm_addr, gemm_wr_data,
    output gemm_grant, gemm_rd_data, gemm_rd_valid,
    output mem_en, mem_rdwr, mem_control, mem_mask, mem_addr, mem_wr_data,
    input  mem_rd_data
  );

  // Requester / memory environment side
  modport master (
    output cpu_en, cpu_rdwr, cpu_mask, cpu_addr, cpu_wr_data,
    input  cpu_rd_data, cpu_rd_valid, cpu_stall,
    output gemm_en, gemm_rdwr, gemm_control, gemm_addr, gemm_wr_data,
    input  gemm_grant, gemm_rd_data, gemm_rd_valid,
    input  mem_en, mem_rdwr, mem_control, mem_mask, mem_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/dmem_port_arbiter_cpu_lane_adapter.sv
// Maps the 32-bit CPU bus onto one lane of the 128-bit memory word and back.
module cpu_lane_adapter
  import dmem_arb_pkg::*;
(
  input  logic [CPU_DW-1:0] cpu_wr_data,
  input  logic [CPU_MW-1:0] cpu_mask,
  input  logic [LANE_W-1:0] wr_lane,
  input  logic [LANE_W-1:0] rd_lane,
  input  logic [MEM_DW-1:0] mem_rd_data,
  output logic [MEM_DW-1:0] wide_wr_data,
  output logic [MASK_W-1:0] wide_mask,
  output logic [CPU_DW-1:0] lane_rd_data
);
  logic [3:0] mask_shift;

  assign mask_shift   = {wr_lane, 2'b00};
  assign wide_wr_data = {4{cpu_wr_data}};
  assign wide_mask    = {{(MASK_W-CPU_MW){1'b0}}, cpu_mask} << mask_shift;
  assign lane_rd_data = mem_rd_data[CPU_DW*rd_lane +: CPU_DW];
endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the wide data-memory port between the CPU bus and GEMM, GEMM first
// with a bounded streak, and routes 1-cycle read returns back to their owner.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4,
  parameter int ADDR_W     = 32
)(
  input logic               clk,
  input logic               rst,
  dmem_port_arbiter_if.slave bus
);
  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_STREAK);

  logic                cpu_gnt;
  logic                gemm_gnt;
  logic [STREAK_W-1:0] streak_p1;
  owner_e              last_owner_p1;
  logic                rd_pend_p1;
  logic [LANE_W-1:0]   lane_p1;
  logic [CPU_DW-1:0]   cpu_rd_hold;
  logic [MEM_DW-1:0]   gemm_rd_hold;
  logic [MEM_DW-1:0]   cpu_wide_data;
  logic [MASK_W-1:0]   cpu_wide_mask;
  logic [CPU_DW-1:0]   cpu_lane_word;
  logic                cpu_rd_vld;
  logic                gemm_rd_vld;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^bus.cpu_addr[1:0];

  cpu_lane_adapter u_lane (
    .cpu_wr_data  (bus.cpu_wr_data),
    .cpu_mask     (bus.cpu_mask),
    .wr_lane      (bus.cpu_addr[3:2]),
    .rd_lane      (lane_p1),
    .mem_rd_data  (bus.mem_rd_data),
    .wide_wr_data (cpu_wide_data),
    .wide_mask    (cpu_wide_mask),
    .lane_rd_data (cpu_lane_word)
  );

  // Stage 0: grant decision on current requests and streak
  always_comb begin
    cpu_gnt  = 1'b0;
    gemm_gnt = 1'b0;
    if (!rst) begin
      if (bus.gemm_en && !(bus.cpu_en && streak_p1 == MAX_S))
        gemm_gnt = 1'b1;
      else if (bus.cpu_en)
        cpu_gnt = 1'b1;
    end
  end

  assign bus.gemm_grant = gemm_gnt;
  assign bus.cpu_stall  = bus.cpu_en & ~cpu_gnt;
  assign bus.mem_en     = cpu_gnt | gemm_gnt;

  always_comb begin
    bus.mem_rdwr    = 1'b0;
    bus.mem_control = '0;
    bus.mem_mask    = '0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = cpu_wide_data;
    if (gemm_gnt) begin
      bus.mem_rdwr    = bus.gemm_rdwr;
      bus.mem_control = bus.gemm_control;
      bus.mem_mask    = bus.gemm_rdwr ? {MASK_W{1'b1}} : '0;
      bus.mem_addr    = bus.gemm_addr;
      bus.mem_wr_data = bus.gemm_wr_data;
    end else if (cpu_gnt) begin
      bus.mem_rdwr = bus.cpu_rdwr;
      bus.mem_mask = bus.cpu_rdwr ? cpu_wide_mask : '0;
      bus.mem_addr = {bus.cpu_addr[ADDR_W-1:4], 4'd0};
    end
  end

  // Stage 1: streak, owner and pending-read registers
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_p1     <= '0;
      last_owner_p1 <= OWN_NONE;
      rd_pend_p1    <= 1'b0;
      cpu_rd_hold   <= '0;
      gemm_rd_hold  <= '0;
    end else begin
      if (cpu_gnt || !bus.cpu_en)
        streak_p1 <= '0;
      else if (gemm_gnt && streak_p1 != MAX_S)
        streak_p1 <= streak_p1 + 1'b1;
      last_owner_p1 <= gemm_gnt ? OWN_GEMM : (cpu_gnt ? OWN_CPU : OWN_NONE);
      rd_pend_p1    <= (gemm_gnt & ~bus.gemm_rdwr) | (cpu_gnt & ~bus.cpu_rdwr);
      if (cpu_rd_vld)  cpu_rd_hold  <= cpu_lane_word;
      if (gemm_rd_vld) gemm_rd_hold <= bus.mem_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    lane_p1 <= bus.cpu_addr[3:2];
  end

  // Stage 1 outputs: memory data returns this cycle, so route it straight through
  assign cpu_rd_vld  = ~rst & rd_pend_p1 & (last_owner_p1 == OWN_CPU);
  assign gemm_rd_vld = ~rst & rd_pend_p1 & (last_owner_p1 == OWN_GEMM);

  assign bus.cpu_rd_valid  = cpu_rd_vld;
  assign bus.gemm_rd_valid = gemm_rd_vld;
  assign bus.cpu_rd_data   = cpu_rd_vld  ? cpu_lane_word   : cpu_rd_hold;
  assign bus.gemm_rd_data  = gemm_rd_vld ? bus.mem_rd_data : gemm_rd_hold;
endmodule
